// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, bit-field positions and ExcCode values.
package cp0_regfile_pkg;

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    localparam int unsigned StatusIeBit  = 0;
    localparam int unsigned StatusExlBit = 1;
    localparam int unsigned StatusImLo   = 8;
    localparam int unsigned StatusImHi   = 15;
    localparam int unsigned StatusBevBit = 22;

    localparam int unsigned CauseExcLo = 2;
    localparam int unsigned CauseExcHi = 6;
    localparam int unsigned CauseIpLo  = 8;
    localparam int unsigned CauseIpHi  = 15;
    localparam int unsigned CauseTiBit = 30;
    localparam int unsigned CauseBdBit = 31;

    typedef enum logic [4:0] {
        ExcInt  = 5'h00,
        ExcMod  = 5'h01,
        ExcTlbl = 5'h02,
        ExcTlbs = 5'h03,
        ExcAdel = 5'h04,
        ExcAdes = 5'h05,
        ExcSys  = 5'h08,
        ExcBp   = 5'h09,
        ExcRi   = 5'h0a,
        ExcOv   = 5'h0c
    } exc_code_e;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == ExcAdel) || (code == ExcAdes);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI is sticky until Compare is written.
module cp0_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o,
    output logic        ti_next_o
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
        end
        // A Compare write clears TI even if the match fires in the same cycle.
        if (compare_we_i) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;
    assign ti_next_o = ti_d;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr plus the Count/Compare timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  ext_int,
    input  logic        except_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] except_pc,
    input  logic        in_delayslot,
    input  logic [31:0] bad_vaddr,
    input  logic        eret,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc,
    output logic        timer_int
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti, ti_next;
    logic        wr_status, wr_cause, wr_epc;

    cp0_timer u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .count_we_i   (we && (waddr == RegCount)),
        .compare_we_i (we && (waddr == RegCompare)),
        .wdata_i      (wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti),
        .ti_next_o    (ti_next)
    );

    // An exception owns Status/Cause/EPC this cycle and ERET owns Status; MTC0 to those drops.
    assign wr_status = we && (waddr == RegStatus) && !except_valid && !eret;
    assign wr_cause  = we && (waddr == RegCause) && !except_valid;
    assign wr_epc    = we && (waddr == RegEpc) && !except_valid;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_hw_d    = {ext_int[5] | ti_next, ext_int[4:0]};

        if (wr_status) begin
            im_d  = wdata[StatusImHi:StatusImLo];
            exl_d = wdata[StatusExlBit];
            ie_d  = wdata[StatusIeBit];
        end
        if (wr_cause) begin
            ip_sw_d = wdata[CauseIpLo+1:CauseIpLo];
        end
        if (wr_epc) begin
            epc_d = wdata;
        end

        if (except_valid) begin
            exc_code_d = exc_code;
            if (!exl_q) begin
                epc_d = in_delayslot ? except_pc - 32'd4 : except_pc;
                bd_d  = in_delayslot;
                exl_d = 1'b1;
            end
            if (is_addr_exc(exc_code)) begin
                badvaddr_d = bad_vaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign cp0_status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cp0_cause  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
    assign cp0_epc    = epc_q;
    assign timer_int  = ti;

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            RegBadVAddr: rdata = badvaddr_q;
            RegCount:    rdata = count;
            RegCompare:  rdata = compare;
            RegStatus:   rdata = cp0_status;
            RegCause:    rdata = cp0_cause;
            RegEpc:      rdata = epc_q;
            default:     rdata = 32'd0;
        endcase
    end

endmodule
